// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared FP types, rounding-mode codes and constants
package riscv_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;
    localparam logic [2:0] FRM_DYN = 3'b111;

    localparam logic [31:0] FP_CANONICAL_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - classify an IEEE single and normalize its significand
module fp_unpack (
    input  logic        [31:0] operand,
    output logic               is_zero,
    output logic               is_inf,
    output logic               is_nan,
    output logic               is_snan,
    output logic        [23:0] mant,
    output logic signed [9:0]  exp
);

    logic [7:0]  exp_field;
    logic [22:0] frac;
    logic [23:0] sig;
    logic [4:0]  lz;
    logic        is_sub;

    assign exp_field = operand[30:23];
    assign frac      = operand[22:0];
    assign sig       = {(exp_field != 8'd0), frac};

    assign is_zero = (exp_field == 8'd0) && (frac == 23'd0);
    assign is_sub  = (exp_field == 8'd0) && (frac != 23'd0);
    assign is_inf  = (exp_field == 8'hFF) && (frac == 23'd0);
    assign is_nan  = (exp_field == 8'hFF) && (frac != 23'd0);
    assign is_snan = is_nan && !frac[22];

    // highest set bit wins, so lz ends as the distance of the MSB from bit 23
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (sig[i]) begin
                lz = 5'(23 - i);
            end
        end
    end

    assign mant = sig << lz;
    assign exp  = is_sub ? (10'sd1 - $signed({5'd0, lz}))
                         : $signed({2'b00, exp_field});

endmodule

// File: rtl/fp_div_iter.sv
// rtl/fp_div_iter.sv - iterative radix-2 restoring single-precision divider
module fp_div_iter
    import riscv_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_flush,
    input  logic        [31:0] i_operand_a,
    input  logic        [31:0] i_operand_b,
    input  logic        [2:0]  i_rounding_mode,
    output logic               o_valid,
    output logic               o_sign,
    output logic signed [9:0]  o_exponent,
    output logic        [24:0] o_mantissa,
    output logic               o_guard,
    output logic               o_round,
    output logic               o_sticky,
    output logic               o_is_zero,
    output logic        [2:0]  o_rounding_mode,
    output logic               o_special,
    output logic        [31:0] o_special_result,
    output fp_flags_t          o_special_flags
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t            state;
    logic              sign_q;
    logic [2:0]        frm_q;
    logic signed [9:0] exp_q;
    logic [23:0]       divisor_q;
    logic [25:0]       rem_q;
    logic [26:0]       quo_q;
    logic [4:0]        cnt_q;
    logic              spec_q;
    logic [31:0]       spec_result_q;
    fp_flags_t         spec_flags_q;

    logic              a_zero, a_inf, a_nan, a_snan;
    logic              b_zero, b_inf, b_nan, b_snan;
    logic [23:0]       a_mant, b_mant;
    logic signed [9:0] a_exp, b_exp;

    fp_unpack u_unpack_a (
        .operand (i_operand_a),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .is_snan (a_snan),
        .mant    (a_mant),
        .exp     (a_exp)
    );

    fp_unpack u_unpack_b (
        .operand (i_operand_b),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .is_snan (b_snan),
        .mant    (b_mant),
        .exp     (b_exp)
    );

    logic              sign_in;
    logic              pre_shift;
    logic signed [9:0] exp_raw;
    logic signed [9:0] exp_start;
    logic              spec_hit;
    logic [31:0]       spec_res;
    fp_flags_t         spec_flg;

    assign sign_in   = i_operand_a[31] ^ i_operand_b[31];
    assign pre_shift = (a_mant < b_mant);
    assign exp_raw   = a_exp - b_exp + 10'sd127;
    assign exp_start = pre_shift ? (exp_raw - 10'sd1) : exp_raw;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = 32'd0;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_res    = FP_CANONICAL_NAN;
            spec_flg.nv = a_snan || b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res    = FP_CANONICAL_NAN;
            spec_flg.nv = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res    = {sign_in, 8'hFF, 23'd0};
            spec_flg.dz = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_res = {sign_in, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // the partial remainder stays below twice the divisor, so 26 bits suffice
    logic        rem_ge;
    logic [25:0] rem_diff;

    assign rem_ge   = (rem_q >= {2'b00, divisor_q});
    assign rem_diff = rem_q - {2'b00, divisor_q};

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            sign_q           <= 1'b0;
            frm_q            <= 3'd0;
            exp_q            <= '0;
            divisor_q        <= '0;
            rem_q            <= '0;
            quo_q            <= '0;
            cnt_q            <= '0;
            spec_q           <= 1'b0;
            spec_result_q    <= '0;
            spec_flags_q     <= '0;
            o_valid          <= 1'b0;
            o_sign           <= 1'b0;
            o_exponent       <= '0;
            o_mantissa       <= '0;
            o_guard          <= 1'b0;
            o_round          <= 1'b0;
            o_sticky         <= 1'b0;
            o_is_zero        <= 1'b0;
            o_rounding_mode  <= 3'd0;
            o_special        <= 1'b0;
            o_special_result <= '0;
            o_special_flags  <= '0;
        end else if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sign_q        <= sign_in;
                        frm_q         <= i_rounding_mode;
                        exp_q         <= exp_start;
                        divisor_q     <= b_mant;
                        rem_q         <= pre_shift ? {1'b0, a_mant, 1'b0} : {2'b00, a_mant};
                        quo_q         <= '0;
                        cnt_q         <= '0;
                        spec_q        <= spec_hit;
                        spec_result_q <= spec_res;
                        spec_flags_q  <= spec_flg;
                        state         <= spec_hit ? DONE : DIV;
                    end
                end
                DIV: begin
                    if (rem_ge) begin
                        quo_q <= {quo_q[25:0], 1'b1};
                        rem_q <= {rem_diff[24:0], 1'b0};
                    end else begin
                        quo_q <= {quo_q[25:0], 1'b0};
                        rem_q <= {rem_q[24:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd26) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_valid         <= 1'b1;
                    o_sign          <= sign_q;
                    o_rounding_mode <= frm_q;
                    if (spec_q) begin
                        o_special        <= 1'b1;
                        o_special_result <= spec_result_q;
                        o_special_flags  <= spec_flags_q;
                        o_exponent       <= '0;
                        o_mantissa       <= '0;
                        o_guard          <= 1'b0;
                        o_round          <= 1'b0;
                        o_sticky         <= 1'b0;
                        o_is_zero        <= (spec_result_q[30:0] == 31'd0);
                    end else begin
                        o_special        <= 1'b0;
                        o_special_result <= '0;
                        o_special_flags  <= '0;
                        o_exponent       <= exp_q;
                        o_mantissa       <= quo_q[26:2];
                        o_guard          <= quo_q[1];
                        o_round          <= quo_q[0];
                        o_sticky         <= (rem_q != 26'd0);
                        o_is_zero        <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// tb/tb_fp_div_iter.sv - directed scoreboard bench for fp_div_iter
module tb_fp_div_iter;
    import riscv_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic               o_ready;
    logic               i_flush;
    logic        [31:0] i_operand_a;
    logic        [31:0] i_operand_b;
    logic        [2:0]  i_rounding_mode;
    logic               o_valid;
    logic               o_sign;
    logic signed [9:0]  o_exponent;
    logic        [24:0] o_mantissa;
    logic               o_guard;
    logic               o_round;
    logic               o_sticky;
    logic               o_is_zero;
    logic        [2:0]  o_rounding_mode;
    logic               o_special;
    logic        [31:0] o_special_result;
    fp_flags_t          o_special_flags;

    fp_div_iter dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_flush          (i_flush),
        .i_operand_a      (i_operand_a),
        .i_operand_b      (i_operand_b),
        .i_rounding_mode  (i_rounding_mode),
        .o_valid          (o_valid),
        .o_sign           (o_sign),
        .o_exponent       (o_exponent),
        .o_mantissa       (o_mantissa),
        .o_guard          (o_guard),
        .o_round          (o_round),
        .o_sticky         (o_sticky),
        .o_is_zero        (o_is_zero),
        .o_rounding_mode  (o_rounding_mode),
        .o_special        (o_special),
        .o_special_result (o_special_result),
        .o_special_flags  (o_special_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              special;
        logic [31:0]       res;
        logic [4:0]        flags;
        logic              sign;
        logic signed [9:0] exp;
        logic [24:0]       mant;
        logic              g;
        logic              r;
        logic              s;
        logic [2:0]        rm;
        int                due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   ncmp  = 0;
    int   nfail = 0;
    int   cyc   = 0;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NV   = 5'b10000;
    localparam logic [4:0] F_DZ   = 5'b01000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk_norm(input logic s, input logic signed [9:0] ex,
                                     input logic [24:0] m, input logic g, input logic r,
                                     input logic st, input logic [2:0] rm);
        exp_t e;
        e.special = 1'b0; e.res = 32'd0; e.flags = F_NONE;
        e.sign = s; e.exp = ex; e.mant = m; e.g = g; e.r = r; e.s = st;
        e.rm = rm; e.due = 0;
        return e;
    endfunction

    function automatic exp_t mk_spec(input logic [31:0] res, input logic [4:0] fl,
                                     input logic [2:0] rm);
        exp_t e;
        e.special = 1'b1; e.res = res; e.flags = fl;
        e.sign = 1'b0; e.exp = '0; e.mant = '0; e.g = 1'b0; e.r = 1'b0; e.s = 1'b0;
        e.rm = rm; e.due = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            ncmp++;
            assert (sb.size() != 0) else begin
                nfail++;
                $error("FAIL unexpected_valid observed=1 expected=0 cycle=%0d", cyc);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("latency", cyc, mon_e.due);
                chk("special", {31'd0, o_special}, {31'd0, mon_e.special});
                chk("rm", {29'd0, o_rounding_mode}, {29'd0, mon_e.rm});
                if (mon_e.special) begin
                    chk("special_result", o_special_result, mon_e.res);
                    chk("special_flags", {27'd0, o_special_flags}, {27'd0, mon_e.flags});
                end else begin
                    chk("sign", {31'd0, o_sign}, {31'd0, mon_e.sign});
                    chk("exponent", {22'd0, o_exponent}, {22'd0, mon_e.exp});
                    chk("mantissa", {7'd0, o_mantissa}, {7'd0, mon_e.mant});
                    chk("grs", {29'd0, o_guard, o_round, o_sticky},
                        {29'd0, mon_e.g, mon_e.r, mon_e.s});
                    chk("is_zero", {31'd0, o_is_zero}, 32'd0);
                end
            end
        end
    end

    // leaves inputs idle at the negedge after the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input bit push, input exp_t e);
        int   t;
        exp_t x;
        t = 0;
        while (o_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'd0, o_ready}, 32'd1);
        i_operand_a = a;
        i_operand_b = b;
        i_rounding_mode = rm;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        x = e;
        x.due = cyc + (x.special ? 1 : 28);
        if (push) sb.push_back(x);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ncmp++;
        assert (sb.size() == 0) else begin
            nfail++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_operand_a = '0;
        i_operand_b = '0;
        i_rounding_mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_mant", {7'd0, o_mantissa}, 32'd0);
        chk("rst_special_result", o_special_result, 32'd0);

        issue(32'h40C0_0000, 32'h4000_0000, FRM_RNE, 1,
              mk_norm(1'b0, 10'sd128, 25'h180_0000, 1'b0, 1'b0, 1'b0, FRM_RNE));
        drain();
        issue(32'h3F80_0000, 32'h4040_0000, FRM_RUP, 1,
              mk_norm(1'b0, 10'sd125, 25'h155_5555, 1'b0, 1'b1, 1'b1, FRM_RUP));
        issue(32'h0000_0001, 32'h3F80_0000, FRM_RTZ, 1,
              mk_norm(1'b0, -10'sd22, 25'h100_0000, 1'b0, 1'b0, 1'b0, FRM_RTZ));
        issue(32'hC0C0_0000, 32'h4000_0000, FRM_RDN, 1,
              mk_norm(1'b1, 10'sd128, 25'h180_0000, 1'b0, 1'b0, 1'b0, FRM_RDN));
        drain();

        issue(32'h3F80_0000, 32'h0000_0000, FRM_RMM, 1, mk_spec(32'h7F80_0000, F_DZ, FRM_RMM));
        issue(32'h0000_0000, 32'h0000_0000, FRM_RNE, 1, mk_spec(32'h7FC0_0000, F_NV, FRM_RNE));
        issue(32'h7F80_0000, 32'hFF80_0000, FRM_RNE, 1, mk_spec(32'h7FC0_0000, F_NV, FRM_RNE));
        issue(32'h7F80_0001, 32'h3F80_0000, FRM_RNE, 1, mk_spec(32'h7FC0_0000, F_NV, FRM_RNE));
        issue(32'h7FC0_0001, 32'h0000_0000, FRM_RNE, 1, mk_spec(32'h7FC0_0000, F_NONE, FRM_RNE));
        issue(32'h7F80_0000, 32'hC000_0000, FRM_RNE, 1, mk_spec(32'hFF80_0000, F_NONE, FRM_RNE));
        issue(32'h8000_0000, 32'h40A0_0000, FRM_RNE, 1, mk_spec(32'h8000_0000, F_NONE, FRM_RNE));
        issue(32'h40A0_0000, 32'h7F80_0000, FRM_RNE, 1, mk_spec(32'h0000_0000, F_NONE, FRM_RNE));
        drain();

        issue(32'h40C0_0000, 32'h4000_0000, FRM_RNE, 0,
              mk_norm(1'b0, 10'sd0, 25'd0, 1'b0, 1'b0, 1'b0, FRM_RNE));
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_ready", {31'd0, o_ready}, 32'd1);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        repeat (30) @(negedge clk);
        issue(32'h3F80_0000, 32'h4040_0000, FRM_RUP, 1,
              mk_norm(1'b0, 10'sd125, 25'h155_5555, 1'b0, 1'b1, 1'b1, FRM_RUP));
        drain();

        issue(32'h40C0_0000, 32'h4000_0000, FRM_RNE, 0,
              mk_norm(1'b0, 10'sd0, 25'd0, 1'b0, 1'b0, 1'b0, FRM_RNE));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        i_flush = 1'b1;
        i_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("midrst_ready", {31'd0, o_ready}, 32'd1);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_mant", {7'd0, o_mantissa}, 32'd0);
        chk("midrst_exp", {22'd0, o_exponent}, 32'd0);
        chk("midrst_misc", {24'd0, o_sign, o_guard, o_round, o_sticky, o_rounding_mode, o_special},
            32'd0);
        repeat (35) @(negedge clk);

        i_operand_a = 32'h40C0_0000;
        i_operand_b = 32'h4000_0000;
        i_rounding_mode = FRM_RNE;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        mon_e = mk_norm(1'b0, 10'sd128, 25'h180_0000, 1'b0, 1'b0, 1'b0, FRM_RNE);
        mon_e.due = cyc + 28;
        sb.push_back(mon_e);
        @(negedge clk);
        i_operand_a = 32'h0000_0000;
        i_operand_b = 32'h0000_0000;
        repeat (20) @(negedge clk);
        chk("busy_ready", {31'd0, o_ready}, 32'd0);
        i_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
